// File: rtl/fir_decim_fifo_if.sv
// ---------------------------------------------------------------------------
// fir_decim_fifo_if
//
// Bundles the producer-side strobe/data, the consumer-side handshake and the
// status outputs of fir_decim_fifo into one interface.
//
// Signals:
//   enable    - FIR output strobe, inP is a valid sample this cycle
//   inP       - FIR output sample (signed, BITWIDTH bits)
//   outReady  - consumer accepts outP this cycle
//   clrOvf    - clears the sticky overflow flag (and dropCount if present)
//   outP      - head-of-FIFO sample (signed, BITWIDTH bits)
//   outValid  - FIFO non-empty, outP valid
//   full      - FIFO holds DEPTH samples
//   overflow  - sticky flag, a kept sample was dropped
//   count     - current FIFO occupancy
//   dropCount - saturating drop counter, present only with FIR_DECIM_DROPCNT_EN
//
// Modports: master (testbench / surrounding logic), slave (the FIFO itself).
// Optional feature macro: FIR_DECIM_DROPCNT_EN
// ---------------------------------------------------------------------------
interface fir_decim_fifo_if #(
    parameter int BITWIDTH = 16,
    parameter int DEPTH    = 8
);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic                       enable;
    logic signed [BITWIDTH-1:0] inP;
    logic                       outReady;
    logic                       clrOvf;
    logic signed [BITWIDTH-1:0] outP;
    logic                       outValid;
    logic                       full;
    logic                       overflow;
    logic [CNTW-1:0]            count;
`ifdef FIR_DECIM_DROPCNT_EN
    logic [7:0]                 dropCount;

    modport master (
        output enable, inP, outReady, clrOvf,
        input  outP, outValid, full, overflow, count, dropCount
    );

    modport slave (
        input  enable, inP, outReady, clrOvf,
        output outP, outValid, full, overflow, count, dropCount
    );
`else
    modport master (
        output enable, inP, outReady, clrOvf,
        input  outP, outValid, full, overflow, count
    );

    modport slave (
        input  enable, inP, outReady, clrOvf,
        output outP, outValid, full, overflow, count
    );
`endif
endinterface

// File: rtl/fir_decim_fifo.sv
// ---------------------------------------------------------------------------
// fir_decim_fifo
//
// Decimates a strobed FIR output stream by M (keeps the 1st, (M+1)th, ...
// enabled sample) and buffers the kept samples in a DEPTH-entry
// first-word-fall-through FIFO with a valid/ready consumer handshake.
// Kept samples that find the FIFO full are dropped and flagged.
//
// Parameters:
//   BITWIDTH - sample width
//   M        - decimation factor (1..256)
//   DEPTH    - FIFO depth, power of 2 (2..256)
//
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous active-high reset
//   bus - fir_decim_fifo_if.slave (strobe/data in, handshake, status out)
//
// Optional feature macro: FIR_DECIM_DROPCNT_EN adds bus.dropCount, an
// 8-bit saturating count of dropped kept samples.
// ---------------------------------------------------------------------------
module fir_decim_fifo #(
    parameter int BITWIDTH = 16,
    parameter int M        = 4,
    parameter int DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst,
    fir_decim_fifo_if.slave bus
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PHW  = (M > 1) ? $clog2(M) : 1;

    logic [BITWIDTH-1:0] mem [DEPTH];

    logic [PHW-1:0]  phase_q, phase_d;
    logic [PTRW-1:0] wrPtr_q, wrPtr_d;
    logic [PTRW-1:0] rdPtr_q, rdPtr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    logic keep;
    logic pop;
    logic push;
    logic drop;

    // Decide keep/pop/push/drop for this cycle and form the next state.
    // A full FIFO still accepts a kept sample when a pop frees a slot in
    // the same cycle; otherwise the kept sample is dropped. Pointers wrap
    // naturally because DEPTH is a power of 2.
    always_comb begin
        keep       = bus.enable && (phase_q == '0);
        pop        = (count_q != '0) && bus.outReady;
        push       = keep && ((count_q != CNTW'(DEPTH)) || pop);
        drop       = keep && !push;

        phase_d    = phase_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (bus.enable) begin
            phase_d = (phase_q == PHW'(M - 1)) ? '0 : phase_q + PHW'(1);
        end
        if (push) begin
            wrPtr_d = wrPtr_q + PTRW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear wins, so the flag stays set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clrOvf) begin
            overflow_d = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= bus.inP;
        end
    end

    // Head sample falls straight through from storage; forced to zero while
    // empty so that reset drives outP to 0 without resetting the array.
    assign bus.outP     = (count_q != '0) ? mem[rdPtr_q] : '0;
    assign bus.outValid = (count_q != '0);
    assign bus.full     = (count_q == CNTW'(DEPTH));
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

`ifdef FIR_DECIM_DROPCNT_EN
    logic [7:0] dropCount_q, dropCount_d;

    // Saturating drop counter; a drop coinciding with a clear restarts at 1.
    always_comb begin
        dropCount_d = dropCount_q;
        if (drop) begin
            if (bus.clrOvf) begin
                dropCount_d = 8'd1;
            end else if (dropCount_q != 8'hFF) begin
                dropCount_d = dropCount_q + 8'd1;
            end
        end else if (bus.clrOvf) begin
            dropCount_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCount_q <= 8'd0;
        end else begin
            dropCount_q <= dropCount_d;
        end
    end

    assign bus.dropCount = dropCount_q;
`endif
endmodule

// File: tb/tb_fir_decim_fifo.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_fifo
//
// Three instances share clk/rst: dut0 (M=4), dut1 (M=1), dut2 (M=3), all
// DEPTH=8. A list-based reference model per instance runs every cycle;
// directed sequences and a table of vectors cover the corner cases, then
// randomized traffic runs against the model.
// Optional feature macro: FIR_DECIM_DROPCNT_EN (dropCount is then checked).
// ---------------------------------------------------------------------------
module tb_fir_decim_fifo;
    localparam int BW    = 16;
    localparam int DEPTH = 8;
    localparam int NI    = 3;

    logic clk;
    logic rst;

    logic                 enA  [NI];
    logic signed [BW-1:0] inA  [NI];
    logic                 rdyA [NI];
    logic                 clrA [NI];

    int vectors;
    int miscompares;

    // Reference model state: a plain list per instance plus counters.
    int mq      [NI][DEPTH+1];
    int mSize   [NI];
    int enCnt   [NI];
    int mOvf    [NI];
    int mDrop   [NI];

    typedef struct {
        int valid;
        int data;
        int cnt;
        int full;
        int ovf;
        int dc;
    } obs_t;

    typedef struct {
        logic en;
        int   inp;
        logic rdy;
        logic clr;
        int   expValid;
        int   expOut;
        int   expCount;
        int   expFull;
        int   expOvf;
    } vec_t;

    fir_decim_fifo_if #(.BITWIDTH(BW), .DEPTH(DEPTH)) if0 ();
    fir_decim_fifo_if #(.BITWIDTH(BW), .DEPTH(DEPTH)) if1 ();
    fir_decim_fifo_if #(.BITWIDTH(BW), .DEPTH(DEPTH)) if2 ();

    assign if0.enable = enA[0];  assign if0.inP = inA[0];
    assign if0.outReady = rdyA[0]; assign if0.clrOvf = clrA[0];
    assign if1.enable = enA[1];  assign if1.inP = inA[1];
    assign if1.outReady = rdyA[1]; assign if1.clrOvf = clrA[1];
    assign if2.enable = enA[2];  assign if2.inP = inA[2];
    assign if2.outReady = rdyA[2]; assign if2.clrOvf = clrA[2];

    fir_decim_fifo #(.BITWIDTH(BW), .M(4), .DEPTH(DEPTH)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    fir_decim_fifo #(.BITWIDTH(BW), .M(1), .DEPTH(DEPTH)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    fir_decim_fifo #(.BITWIDTH(BW), .M(3), .DEPTH(DEPTH)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mOf(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic obs_t sample(input int idx);
        obs_t o;
        o.dc = 0;
        case (idx)
            0: begin
                o.valid = int'(if0.outValid); o.data = int'(if0.outP); o.cnt = int'(if0.count);
                o.full = int'(if0.full); o.ovf = int'(if0.overflow);
`ifdef FIR_DECIM_DROPCNT_EN
                o.dc = int'(if0.dropCount);
`endif
            end
            1: begin
                o.valid = int'(if1.outValid); o.data = int'(if1.outP); o.cnt = int'(if1.count);
                o.full = int'(if1.full); o.ovf = int'(if1.overflow);
`ifdef FIR_DECIM_DROPCNT_EN
                o.dc = int'(if1.dropCount);
`endif
            end
            default: begin
                o.valid = int'(if2.outValid); o.data = int'(if2.outP); o.cnt = int'(if2.count);
                o.full = int'(if2.full); o.ovf = int'(if2.overflow);
`ifdef FIR_DECIM_DROPCNT_EN
                o.dc = int'(if2.dropCount);
`endif
            end
        endcase
        return o;
    endfunction

    task automatic compare(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic en, input int inp,
                                 input logic rdy, input logic clr);
        enA[idx]  = en;
        inA[idx]  = inp[BW-1:0];
        rdyA[idx] = rdy;
        clrA[idx] = clr;
    endtask

    task automatic idleAll();
        for (int i = 0; i < NI; i++) applyStimulus(i, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Model: pop the head if ready, then append the kept sample if there is
    // room, otherwise count it as a drop.
    task automatic modelStep(input int idx);
        bit kept;
        bit pop;
        bit drop;
        kept = enA[idx] && ((enCnt[idx] % mOf(idx)) == 0);
        pop  = (mSize[idx] > 0) && rdyA[idx];
        drop = 1'b0;
        if (enA[idx]) enCnt[idx]++;
        if (pop) begin
            for (int k = 0; k < mSize[idx] - 1; k++) mq[idx][k] = mq[idx][k+1];
            mSize[idx]--;
        end
        if (kept) begin
            if (mSize[idx] < DEPTH) begin
                mq[idx][mSize[idx]] = int'(inA[idx]);
                mSize[idx]++;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) mOvf[idx] = 1;
        else if (clrA[idx]) mOvf[idx] = 0;
        if (drop) begin
            if (clrA[idx]) mDrop[idx] = 1;
            else if (mDrop[idx] < 255) mDrop[idx]++;
        end else if (clrA[idx]) begin
            mDrop[idx] = 0;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            mSize[i] = 0; enCnt[i] = 0; mOvf[i] = 0; mDrop[i] = 0;
        end
    endtask

    task automatic checkOutput(input int idx);
        obs_t o;
        o = sample(idx);
        compare($sformatf("outValid%0d", idx), o.valid, (mSize[idx] > 0) ? 1 : 0);
        compare($sformatf("count%0d", idx), o.cnt, mSize[idx]);
        compare($sformatf("full%0d", idx), o.full, (mSize[idx] == DEPTH) ? 1 : 0);
        compare($sformatf("overflow%0d", idx), o.ovf, mOvf[idx]);
        if (mSize[idx] > 0) compare($sformatf("outP%0d", idx), o.data, mq[idx][0]);
`ifdef FIR_DECIM_DROPCNT_EN
        compare($sformatf("dropCount%0d", idx), o.dc, mDrop[idx]);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NI; i++) modelStep(i);
        #1;
        for (int i = 0; i < NI; i++) checkOutput(i);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic doReset();
        obs_t o;
        rst = 1'b1;
        #1;
        modelReset();
        for (int i = 0; i < NI; i++) begin
            o = sample(i);
            compare("rstValid", o.valid, 0);
            compare("rstCount", o.cnt, 0);
            compare("rstFull", o.full, 0);
            compare("rstOvf", o.ovf, 0);
            compare("rstOutP", o.data, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl [19];
    int   got [$];
    int   exp32 [4];
    int   exp34 [8];
    int   exp37 [3];

    initial begin
        obs_t o;
        int   n;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idleAll();
        modelReset();

        // Table for dut1 (M=1): fill past full with outReady=0, then drain.
        for (int k = 0; k < 10; k++) begin
            tbl[k] = '{en: 1'b1, inp: 100 + k, rdy: 1'b0, clr: 1'b0, expValid: 1,
                       expOut: 100, expCount: (k + 1 > 8) ? 8 : k + 1,
                       expFull: (k >= 7) ? 1 : 0, expOvf: (k >= 8) ? 1 : 0};
        end
        for (int j = 0; j < 8; j++) begin
            tbl[10+j] = '{en: 1'b0, inp: 0, rdy: 1'b1, clr: 1'b0, expValid: (j < 7) ? 1 : 0,
                          expOut: 101 + j, expCount: 7 - j, expFull: 0, expOvf: 1};
        end
        tbl[18] = '{en: 1'b0, inp: 0, rdy: 1'b0, clr: 1'b1, expValid: 0,
                    expOut: 0, expCount: 0, expFull: 0, expOvf: 0};
        exp32 = '{0, 4, 8, 12};
        exp34 = '{21, 22, 23, 24, 25, 26, 27, 7};
        exp37 = '{-5, -2, 1};

        #2;
        doReset();

        // M=4 streaming with outReady=1: only every 4th sample emerges.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b1, i, 1'b1, 1'b0);
            tick();
            o = sample(0);
            if (o.valid != 0) got.push_back(o.data);
        end
        applyStimulus(0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        compare("m4KeptCount", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) compare("m4Seq", got[i], exp32[i]);
        got.delete();

        // Mid-stream reset with count=5, phase=2 (18 enabled samples).
        doReset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 1'b1, 200 + i, 1'b0, 1'b0);
            tick();
        end
        o = sample(0);
        compare("preRstCount", o.cnt, 5);
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
        doReset();
        applyStimulus(0, 1'b1, 77, 1'b0, 1'b0);
        tick();
        o = sample(0);
        compare("postRstValid", o.valid, 1);
        compare("postRstOutP", o.data, 77);
        applyStimulus(0, 1'b0, 0, 1'b1, 1'b0);
        tick();

        // M=3, enable toggling, negative samples.
        n = 0;
        for (int c = 0; c < 18; c++) begin
            if ((c % 2) == 0) begin
                applyStimulus(2, 1'b1, -5 + n, 1'b1, 1'b0);
                n++;
            end else begin
                applyStimulus(2, 1'b0, 0, 1'b1, 1'b0);
            end
            tick();
            o = sample(2);
            if (o.valid != 0) got.push_back(o.data);
        end
        applyStimulus(2, 1'b0, 0, 1'b1, 1'b0);
        tick();
        compare("m3KeptCount", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) compare("m3Seq", got[i], exp37[i]);
        got.delete();
        idleAll();

        // Table-driven vectors on dut1.
        for (int r = 0; r < 19; r++) begin
            applyStimulus(1, tbl[r].en, tbl[r].inp, tbl[r].rdy, tbl[r].clr);
            tick();
            o = sample(1);
            compare("tblValid", o.valid, tbl[r].expValid);
            compare("tblCount", o.cnt, tbl[r].expCount);
            compare("tblFull", o.full, tbl[r].expFull);
            compare("tblOvf", o.ovf, tbl[r].expOvf);
            if (tbl[r].expValid != 0) compare("tblOutP", o.data, tbl[r].expOut);
        end

        // Full FIFO with simultaneous push and pop: no drop, order kept.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1'b1, 20 + i, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1, 1'b1, 7, 1'b1, 1'b0);
        tick();
        o = sample(1);
        compare("pushPopCount", o.cnt, 8);
        compare("pushPopOvf", o.ovf, 0);
        applyStimulus(1, 1'b0, 0, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            o = sample(1);
            compare("pushPopOrder", o.data, exp34[j]);
            tick();
        end

        // Drop coinciding with clrOvf, then saturation of the drop counter.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1'b1, 300 + i, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1, 1'b1, 55, 1'b0, 1'b1);
        tick();
        o = sample(1);
        compare("dropClrOvf", o.ovf, 1);
`ifdef FIR_DECIM_DROPCNT_EN
        compare("dropClrCount", o.dc, 1);
`endif
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 1'b1, i, 1'b0, 1'b0);
            tick();
        end
        o = sample(1);
        compare("satOvf", o.ovf, 1);
`ifdef FIR_DECIM_DROPCNT_EN
        compare("satCount", o.dc, 255);
`endif
        applyStimulus(1, 1'b0, 0, 1'b1, 1'b1);
        tick();
        applyStimulus(1, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        idleAll();

        // Randomized traffic on all instances against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                applyStimulus(i, ($urandom_range(0, 3) != 0), int'($urandom),
                              ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
            if ($urandom_range(0, 499) == 0) doReset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fir_decim_fifo.md
FIR_DECIM_FIFO -- requirements
Module: fir_decim_fifo

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, sample width in bits (matches the FIR output width).
REQ-002 SHALL have parameter M, default 4, decimation factor, legal range 1..256.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO depth in samples, power of 2, legal range 2..256.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit: FIR output strobe; inP is a valid FIR sample in this cycle.
REQ-007 SHALL have port inP, input, BITWIDTH bits, signed: FIR output sample.
REQ-008 SHALL have port outReady, input, 1 bit: the consumer accepts outP this cycle.
REQ-009 SHALL have port clrOvf, input, 1 bit: clears the overflow flag.
REQ-010 SHALL have port outP, output, BITWIDTH bits, signed: head-of-FIFO sample.
REQ-011 SHALL have port outValid, output, 1 bit: the FIFO is non-empty and outP is valid.
REQ-012 SHALL have port full, output, 1 bit: the FIFO holds DEPTH samples.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a kept sample was dropped.
REQ-014 SHALL have port count, output, clog2(DEPTH+1) bits: current FIFO occupancy.

Function
REQ-015 SHALL keep a phase counter 0..M-1 that advances by 1 on each cycle with enable=1 and wraps from M-1 to 0; it SHALL hold when enable=0.
REQ-016 SHALL mark a sample as kept when enable=1 and phase=0, so the 1st, (M+1)th, (2M+1)th, ... enabled samples after reset are kept. With M=1 every enabled sample is kept.
REQ-017 SHALL pop one sample when outValid=1 and outReady=1 at a rising edge.
REQ-018 SHALL push a kept sample when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-019 SHALL discard a kept sample that cannot be pushed and set overflow=1 at that edge; the phase counter SHALL still advance.
REQ-020 On a same-cycle push and pop, count SHALL remain unchanged and both pointers SHALL advance.
REQ-021 SHALL present the head sample with first-word-fall-through behaviour: a sample pushed at edge k is on outP with outValid=1 immediately after edge k when the FIFO was empty (1-cycle latency).
REQ-022 SHALL wrap the read and write pointers modulo DEPTH; outValid SHALL equal (count!=0) and full SHALL equal (count==DEPTH).
REQ-023 SHALL hold outP stable while outValid=1 and outReady=0.
REQ-024 outP SHALL be don't-care while outValid=0; the bench SHALL NOT check it in that state.
REQ-025 SHALL clear overflow when clrOvf=1 at an edge; if a drop occurs in the same cycle, the set SHALL take priority and overflow SHALL remain 1.
REQ-026 SHALL pass samples bit-exact with no arithmetic on the data path.

Reset
REQ-027 While rst=1, SHALL asynchronously force phase=0, both pointers=0, count=0, outValid=0, full=0, overflow=0, and outP=0.
REQ-028 Reset asserted mid-stream SHALL discard all FIFO contents; after rst deasserts, the first enabled sample SHALL be kept (phase=0).
REQ-029 Storage array contents SHALL NOT require reset.

Configuration
REQ-030 When macro FIR_DECIM_DROPCNT_EN is defined, SHALL add output port dropCount, 8 bits, which increments on each dropped kept sample, saturates at 255, and clears on reset or clrOvf=1 (a same-cycle drop wins and gives 1 when clearing from any value).
REQ-031 When FIR_DECIM_DROPCNT_EN is undefined, port dropCount and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Set M=4, DEPTH=8, enable=1 continuously, inP=0,1,2,...,15, outReady=1 -> outP sequence is 0,4,8,12, each sample valid exactly one cycle after its push.
REQ-033 Set M=1, DEPTH=8, outReady=0, and push 10 samples 100..109 -> count=8, full=1, overflow=1 after the 9th sample, and the FIFO holds 100..107; then outReady=1 drains 100..107 in order.
REQ-034 Fill to full with M=1, then hold enable=1 and outReady=1 together with inP=7 -> count stays 8, no overflow, and 7 appears after the 8 older samples.
REQ-035 Assert rst for 1 cycle mid-stream with count=5 and phase=2 -> outValid=0 and count=0 immediately; the next enabled sample is kept.
REQ-036 Drive a drop and clrOvf=1 in the same cycle -> overflow=1; with FIR_DECIM_DROPCNT_EN, dropCount=1; after 300 further drops, dropCount=255.
REQ-037 Use M=3 with enable toggling 1,0,1,0,... and inP=-5,-4,... -> kept samples are the 1st, 4th, 7th enabled values, and negative values pass bit-exact.
